// File: rtl/fsm_trace_logger_pkg.sv
// Shared types and helpers for the FSM trace logger, its event FIFO and the bench.
package fsm_trace_logger_pkg;

    localparam int TRACE_CODE_W   = 3;
    localparam int TRACE_DWELL_W  = 16;
    localparam int TRACE_MAX_CODE = 4;

    typedef struct packed {
        logic                     err;
        logic [TRACE_CODE_W-1:0]  prevCode;
        logic [TRACE_CODE_W-1:0]  newCode;
        logic [TRACE_DWELL_W-1:0] dwell;
    } trace_event_t;

    // A step is legal when it advances by one inside 0..maxCode or returns to 0 from a valid code.
    function automatic logic legal_step(input int unsigned prevCode,
                                        input int unsigned newCode,
                                        input int unsigned maxCode);
        if (prevCode > maxCode || newCode > maxCode) begin
            return 1'b0;
        end
        if (newCode == 0) begin
            return 1'b1;
        end
        return (prevCode < maxCode) && (newCode == prevCode + 1);
    endfunction

endpackage

// File: rtl/fsm_trace_logger_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always visible on data_o.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstN_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstN_i && !flush_i && doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fsm_trace_logger.sv
// Watches an upstream FSM state code, logs every code change with its dwell time into a
// FIFO, and keeps lap, illegal-transition and overflow bookkeeping.
module fsm_trace_logger
    import fsm_trace_logger_pkg::*;
#(
    parameter int CODE_W   = TRACE_CODE_W,
    parameter int DWELL_W  = TRACE_DWELL_W,
    parameter int DEPTH    = 8,
    parameter int MAX_CODE = TRACE_MAX_CODE
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [CODE_W-1:0]             q_in,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [2*CODE_W+DWELL_W:0]     ev_data,
    output logic [$clog2(DEPTH):0]        ev_count,
    output logic [7:0]                    lap_cnt,
    output logic                          seq_err,
    output logic                          overflow
);

    localparam int                 EV_W      = 1 + 2*CODE_W + DWELL_W;
    localparam logic [CODE_W-1:0]  MAX_C     = CODE_W'(MAX_CODE);
    localparam logic [DWELL_W-1:0] DWELL_SAT = '1;

    logic [CODE_W-1:0]  qPrev_q, qPrev_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         lapCnt_q, lapCnt_d;
    logic               seqErr_q, seqErr_d;
    logic               overflow_q, overflow_d;
    logic               change, stepErr, isLap, push, pop, fifoFull, fifoEmpty;
    logic [EV_W-1:0]    pushData;

    assign change   = en && (q_in != qPrev_q);
    assign stepErr  = !legal_step(32'(qPrev_q), 32'(q_in), 32'(MAX_CODE));
    assign isLap    = (qPrev_q == MAX_C) && (q_in == '0);
    assign push     = rstN && !clr && change;
    assign pop      = !fifoEmpty && ev_ready;
    assign pushData = {stepErr, qPrev_q, q_in, dwell_q};

    always_comb begin
        qPrev_d    = qPrev_q;
        dwell_d    = dwell_q;
        lapCnt_d   = lapCnt_q;
        seqErr_d   = seqErr_q;
        overflow_d = overflow_q;
        if (clr) begin
            qPrev_d    = q_in;
            dwell_d    = '0;
            lapCnt_d   = '0;
            seqErr_d   = 1'b0;
            overflow_d = 1'b0;
        end else if (change) begin
            // Laps count even when the event itself is dropped by a full FIFO.
            qPrev_d = q_in;
            dwell_d = DWELL_W'(1);
            if (isLap) begin
                lapCnt_d = lapCnt_q + 8'd1;
            end
            if (stepErr) begin
                seqErr_d = 1'b1;
            end
            if (fifoFull && !pop) begin
                overflow_d = 1'b1;
            end
        end else if (en && dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            qPrev_q    <= '0;
            dwell_q    <= '0;
            lapCnt_q   <= '0;
            seqErr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            qPrev_q    <= qPrev_d;
            dwell_q    <= dwell_d;
            lapCnt_q   <= lapCnt_d;
            seqErr_q   <= seqErr_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rstN_i  (rstN),
        .flush_i (clr),
        .push_i  (push),
        .data_i  (pushData),
        .pop_i   (pop),
        .data_o  (ev_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (ev_count)
    );

    assign ev_valid = !fifoEmpty;
    assign lap_cnt  = lapCnt_q;
    assign seq_err  = seqErr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fsm_trace_logger.sv
// Bench for fsm_trace_logger: two instances (16-bit and 4-bit dwell) share one stimulus
// stream and are checked every cycle against a queue-based event model.
module tb_fsm_trace_logger;

    logic        clk = 1'b0;
    logic        rstN, en, clr, evReady;
    logic [2:0]  qIn;

    logic        evValidA, seqErrA, overflowA;
    logic [22:0] evDataA;
    logic [3:0]  evCountA;
    logic [7:0]  lapCntA;
    logic        evValidB, seqErrB, overflowB;
    logic [10:0] evDataB;
    logic [3:0]  evCountB;
    logic [7:0]  lapCntB;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit err;
        int prevCode;
        int newCode;
        int dwell;
    } modelEv_t;

    modelEv_t evQ[$];
    int       mQ, mDwell, mLap;
    bit       mSeqErr, mOverflow;

    always #5 clk = ~clk;

    fsm_trace_logger dutA (
        .clk(clk), .rstN(rstN), .q_in(qIn), .en(en), .clr(clr), .ev_ready(evReady),
        .ev_valid(evValidA), .ev_data(evDataA), .ev_count(evCountA), .lap_cnt(lapCntA),
        .seq_err(seqErrA), .overflow(overflowA)
    );

    fsm_trace_logger #(.DWELL_W(4)) dutB (
        .clk(clk), .rstN(rstN), .q_in(qIn), .en(en), .clr(clr), .ev_ready(evReady),
        .ev_valid(evValidB), .ev_data(evDataB), .ev_count(evCountB), .lap_cnt(lapCntB),
        .seq_err(seqErrB), .overflow(overflowB)
    );

    // Legal moves: one step forward within 0..4, or back to 0 from any valid code.
    function automatic bit isLegal(int p, int n);
        if (p > 4 || n > 4) return 1'b0;
        return (n == 0) || (n == p + 1);
    endfunction

    function automatic logic [31:0] packEv(modelEv_t e, int dwellW);
        int sat = (1 << dwellW) - 1;
        int d   = (e.dwell > sat) ? sat : e.dwell;
        int v   = (int'(e.err) << (6 + dwellW)) + (e.prevCode << (3 + dwellW))
                + (e.newCode << dwellW) + d;
        return 32'(v);
    endfunction

    function automatic void modelEdge();
        bit doPop;
        modelEv_t e;
        doPop = evReady && (evQ.size() != 0);
        if (!rstN) begin
            mQ = 0; mDwell = 0; mLap = 0; mSeqErr = 0; mOverflow = 0;
            evQ.delete();
        end else if (clr) begin
            mQ = int'(qIn); mDwell = 0; mLap = 0; mSeqErr = 0; mOverflow = 0;
            evQ.delete();
        end else begin
            if (doPop) void'(evQ.pop_front());
            if (en) begin
                if (int'(qIn) != mQ) begin
                    e.err      = !isLegal(mQ, int'(qIn));
                    e.prevCode = mQ;
                    e.newCode  = int'(qIn);
                    e.dwell    = mDwell;
                    if (e.err) mSeqErr = 1;
                    if (mQ == 4 && qIn == 3'd0) mLap = (mLap + 1) % 256;
                    if (evQ.size() < 8) evQ.push_back(e);
                    else mOverflow = 1;
                    mQ     = int'(qIn);
                    mDwell = 1;
                end else begin
                    mDwell++;
                end
            end
        end
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        compare("A.ev_valid", 32'(evValidA), 32'(evQ.size() != 0));
        compare("A.ev_count", 32'(evCountA), 32'(evQ.size()));
        compare("A.lap_cnt",  32'(lapCntA),  32'(mLap));
        compare("A.seq_err",  32'(seqErrA),  32'(mSeqErr));
        compare("A.overflow", 32'(overflowA), 32'(mOverflow));
        compare("B.ev_valid", 32'(evValidB), 32'(evQ.size() != 0));
        compare("B.ev_count", 32'(evCountB), 32'(evQ.size()));
        compare("B.lap_cnt",  32'(lapCntB),  32'(mLap));
        compare("B.seq_err",  32'(seqErrB),  32'(mSeqErr));
        compare("B.overflow", 32'(overflowB), 32'(mOverflow));
        if (evQ.size() != 0) begin
            compare("A.ev_data", 32'(evDataA), packEv(evQ[0], 16));
            compare("B.ev_data", 32'(evDataB), packEv(evQ[0], 4));
        end
    endtask

    task automatic applyStimulus(input int q, input bit e, input bit c, input bit rdy, input bit rst);
        qIn     = 3'(q);
        en      = e;
        clr     = c;
        evReady = rdy;
        rstN    = rst;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int seq1[12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 4, 0};
        int fill[9]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4};
        int r, nq;

        // Reset state.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        compare("RST.ev_valid", 32'(evValidA), 32'd0);

        // Legal lap with immediate draining.
        foreach (seq1[i]) applyStimulus(seq1[i], 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 1);
        compare("T1.lap_cnt", 32'(lapCntA), 32'd1);
        compare("T1.seq_err", 32'(seqErrA), 32'd0);

        // Illegal jump 1->3, then an out-of-range code.
        applyStimulus(1, 1, 1, 0, 1);
        applyStimulus(3, 1, 0, 0, 1);
        compare("T2.event", 32'(evDataA), 32'({1'b1, 3'd1, 3'd3, 16'd0}));
        compare("T2.seq_err", 32'(seqErrA), 32'd1);
        applyStimulus(6, 1, 0, 0, 1);
        applyStimulus(6, 1, 0, 1, 1);
        applyStimulus(6, 1, 0, 1, 1);
        compare("T2.seq_err_sticky", 32'(seqErrA), 32'd1);
        applyStimulus(0, 1, 1, 1, 1);
        compare("T2.seq_err_clr", 32'(seqErrA), 32'd0);

        // Overflow: nine changes with no consumer, then drain.
        foreach (fill[i]) applyStimulus(fill[i], 1, 0, 0, 1);
        compare("T3.ev_count", 32'(evCountA), 32'd8);
        compare("T3.overflow", 32'(overflowA), 32'd1);
        for (int i = 0; i < 9; i++) applyStimulus(4, 0, 0, 1, 1);

        // Full FIFO with simultaneous pop and push.
        applyStimulus(0, 1, 1, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(fill[i], 1, 0, 0, 1);
        applyStimulus(4, 1, 0, 1, 1);
        compare("T4.ev_count", 32'(evCountA), 32'd8);
        compare("T4.overflow", 32'(overflowA), 32'd0);
        for (int i = 0; i < 9; i++) applyStimulus(4, 0, 0, 1, 1);

        // Dwell saturation on the 4-bit instance.
        applyStimulus(2, 1, 1, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(2, 1, 0, 0, 1);
        applyStimulus(3, 1, 0, 0, 1);
        compare("T5.dwellB", 32'(evDataB[3:0]), 32'd15);
        compare("T5.dwellA", 32'(evDataA[15:0]), 32'd20);

        // Reset mid-stream, then disabled tracking.
        applyStimulus(0, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(fill[i], 1, 0, 0, 1);
        compare("T6.count_before", 32'(evCountA), 32'd5);
        applyStimulus(0, 1, 0, 0, 0);
        compare("T6.ev_valid", 32'(evValidA), 32'd0);
        compare("T6.lap_cnt", 32'(lapCntA), 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(int'($urandom_range(0, 7)), 0, 0, 1, 1);
        compare("T6.no_events", 32'(evCountA), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      nq = mQ;
            else if (r < 90) nq = (mQ >= 4) ? 0 : mQ + 1;
            else             nq = int'($urandom_range(0, 7));
            applyStimulus(nq,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) < 2,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 99) >= 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
